// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : N-to-1 round-robin stream arbiter. Grants last up to BURST beats
//            and feed a registered output stage. Defining STREAM_ARB_SRC_EN
//            adds the down_src port.
// Revision : 1.0  initial release
// ============================================================================
module stream_rr_arbiter #(
  parameter int DW    = 32,
  parameter int N     = 4,
  parameter int BURST = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_valid,
  output logic [N-1:0]    up_ready,
  input  logic [N*DW-1:0] up_data,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [DW-1:0]   down_data
`ifdef STREAM_ARB_SRC_EN
  ,
  output logic [IW-1:0]   down_src
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [15:0]   beat_cnt_q, beat_cnt_d;
  logic          down_valid_q, down_valid_d;
  logic [DW-1:0] down_data_q, down_data_d;

  logic [IW-1:0] winner;
  logic          winner_found;
  logic [IW:0]   scan_idx;
  logic [IW-1:0] owner_inc;
  logic          owner_valid;
  logic          owner_ready;
  logic          xfer;
  logic [16:0]   beat_cnt_inc;

  // Round-robin search: first asserted up_valid at or after ptr, wrapping.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N)) begin
        scan_idx = scan_idx - (IW+1)'(N);
      end
      if (!winner_found && up_valid[scan_idx[IW-1:0]]) begin
        winner       = scan_idx[IW-1:0];
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    up_ready = '0;
    if (!rst && (state_q == GRANT)) begin
      up_ready[owner_q] = !down_valid_q || down_ready;
    end
  end

  assign owner_inc    = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign owner_valid  = up_valid[owner_q];
  assign owner_ready  = up_ready[owner_q];
  assign xfer         = owner_valid && owner_ready;
  assign beat_cnt_inc = {1'b0, beat_cnt_q} + 17'd1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;

    // Output stage runs independently of the grant so a pending beat
    // survives a release.
    if (xfer) begin
      down_valid_d = 1'b1;
      down_data_d  = up_data[owner_q*DW +: DW];
    end else if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d    = GRANT;
          owner_d    = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_inc[15:0];
          if (beat_cnt_inc == 17'(BURST)) begin
            state_d = IDLE;
            ptr_d   = owner_inc;
          end
        end else if (owner_ready && !owner_valid) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;

`ifdef STREAM_ARB_SRC_EN
  logic [IW-1:0] down_src_q, down_src_d;

  always_comb begin
    down_src_d = down_src_q;
    if (xfer) begin
      down_src_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_src_q <= '0;
    end else begin
      down_src_q <= down_src_d;
    end
  end

  assign down_src = down_src_q;
`endif

endmodule
`default_nettype wire
